// File: rtl/fip_32_sqrt_seq.sv
// -----------------------------------------------------------------------------
// fip_32_sqrt_seq
//
// Sequential square root of a signed Q16.16 fixed-point operand, one result
// bit per clock. The operand is widened to N = {radicand, FRACTIONAL_BITS
// zeros}, which makes the integer square root of N equal to the Q16.16
// square root of the operand. A restoring digit-by-digit algorithm consumes
// N two bits at a time, MSB pair first.
//
// Negative operands skip the computation entirely. They produce o_root = 0
// with o_invalid set, and the result is presented on the cycle right after
// the operand is accepted.
//
// Build option:
//   FIP_SQRT_ROUND_EN - when defined, the result is rounded to nearest
//                       instead of truncated. Latency does not change.
//
// Parameters:
//   FRACTIONAL_BITS - fractional bits of operand and result (16)
//   ITERATIONS      - result bits resolved, one per CALC step (24)
//
// Ports:
//   clk        in   single clock; all state changes on its rising edge
//   rst_n      in   asynchronous active-low reset
//   i_valid    in   operand offered
//   o_ready    out  block can accept an operand (high only while IDLE)
//   i_radicand in   signed Q16.16 operand
//   o_valid    out  result available (high only while DONE)
//   i_ready    in   consumer takes the result
//   o_root     out  Q16.16 square root; never negative
//   o_invalid  out  the operand was negative; only meaningful with o_valid
// -----------------------------------------------------------------------------
module fip_32_sqrt_seq #(
  parameter int FRACTIONAL_BITS = 16,
  parameter int ITERATIONS      = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_radicand,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_root,
  output logic        o_invalid
);

  localparam int NW   = 32 + FRACTIONAL_BITS;  // widened operand width
  localparam int RW   = ITERATIONS;            // partial root width
  localparam int REMW = ITERATIONS + 2;        // remainder width
  localparam int CW   = $clog2(ITERATIONS + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   rad_q,   rad_d;
  logic [REMW-1:0] rem_q,   rem_d;
  logic [RW-1:0]   root_q,  root_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [31:0]     res_q,   res_d;
  logic            inv_q,   inv_d;

  // Datapath for one restoring step. Shifting in the next pair needs two
  // extra bits beyond the remainder register before the subtraction.
  logic [REMW+1:0] rem_sh;
  logic [REMW+1:0] trial;
  logic [REMW+1:0] diff;
  logic            round_up;
  logic [31:0]     res_fin;

  always_comb begin
    rem_sh = {rem_q, rad_q[NW-1 -: 2]};
    trial  = {2'b00, root_q, 2'b01};
    diff   = rem_sh - trial;

`ifdef FIP_SQRT_ROUND_EN
    // With root r and remainder N - r*r, the value sqrt(N) is at least
    // r + 0.5 exactly when the remainder is greater than r.
    round_up = (rem_q > {2'b00, root_q});
`else
    round_up = 1'b0;
`endif

    res_fin = {{(32 - RW){1'b0}}, root_q} + {31'd0, round_up};
  end

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    inv_d   = inv_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i_radicand[31]) begin
            res_d   = '0;
            inv_d   = 1'b1;
            state_d = DONE;
          end else begin
            rad_d   = {i_radicand, {FRACTIONAL_BITS{1'b0}}};
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        // Counts 0..ITERATIONS-1 are the digit steps. The cycle at count
        // ITERATIONS applies optional rounding and publishes the result.
        // This gives ITERATIONS+1 edges from accept to o_valid.
        if (cnt_q == CW'(ITERATIONS)) begin
          res_d   = res_fin;
          inv_d   = 1'b0;
          state_d = DONE;
        end else begin
          rad_d = {rad_q[NW-3:0], 2'b00};
          if (rem_sh >= trial) begin
            rem_d  = diff[REMW-1:0];
            root_d = {root_q[RW-2:0], 1'b1};
          end else begin
            rem_d  = rem_sh[REMW-1:0];
            root_d = {root_q[RW-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign o_root    = res_q;
  assign o_invalid = inv_q;

endmodule

// File: tb/tb_fip_32_sqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_fip_32_sqrt_seq
//
// Directed table of Q16.16 operands with hand-computed roots. It also runs
// hand-written sequences for back-pressure in DONE and for an asynchronous
// reset in the middle of CALC. Expected rounded values are selected with
// FIP_SQRT_ROUND_EN so that the bench matches the build under test.
// -----------------------------------------------------------------------------
module tb_fip_32_sqrt_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_radicand;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_root;
  logic        o_invalid;

  int n_vec = 0;
  int n_err = 0;

  fip_32_sqrt_seq #(
    .FRACTIONAL_BITS(16),
    .ITERATIONS(24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_radicand(i_radicand),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_root    (o_root),
    .o_invalid (o_invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] radicand;
    logic [31:0] exp_root;
    logic        exp_inv;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Offers one operand, measures the edges from the accept edge to o_valid,
  // and checks the result. It then holds i_ready low for hold_cycles cycles
  // and completes the handshake.
  task automatic run_op(input logic [31:0] rad, input logic [31:0] exp_root,
                        input logic exp_inv, input int hold_cycles);
    int          lat;
    int          exp_lat;
    logic [31:0] root_seen;
    exp_lat = exp_inv ? 0 : 25;
    @(negedge clk);
    check("ready_before_accept", {31'd0, o_ready}, 32'd1);
    i_valid    = 1'b1;
    i_radicand = rad;
    i_ready    = (hold_cycles == 0);
    @(posedge clk);                     // accept edge
    #1;
    i_valid    = 1'b0;
    i_radicand = $urandom();            // must be ignored outside IDLE
    lat = 0;
    while (!o_valid && lat < 100) begin
      if (lat == 3) i_valid = 1'b1;     // offers made mid-CALC must be ignored
      @(posedge clk);
      #1;
      lat++;
    end
    i_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("root", o_root, exp_root);
    check("invalid", {31'd0, o_invalid}, {31'd0, exp_inv});
    check("ready_in_done", {31'd0, o_ready}, 32'd0);
    $display("op radicand=0x%08h root=0x%08h invalid=%0d latency=%0d",
             rad, o_root, o_invalid, lat);
    root_seen = o_root;
    for (int h = 0; h < hold_cycles; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'd0, o_valid}, 32'd1);
      check("hold_root", o_root, root_seen);
      check("hold_ready", {31'd0, o_ready}, 32'd0);
    end
    i_ready = 1'b1;
    @(posedge clk);                     // handshake edge
    #1;
    check("ready_after_handshake", {31'd0, o_ready}, 32'd1);
    check("valid_after_handshake", {31'd0, o_valid}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int   edges;
    logic seen_valid;

    vecs[0]  = '{32'h0004_0000, 32'h0002_0000, 1'b0};   // 4.0 -> 2.0
`ifdef FIP_SQRT_ROUND_EN
    vecs[1]  = '{32'h0002_0000, 32'h0001_6A0A, 1'b0};   // sqrt(2) rounded
    vecs[2]  = '{32'h0003_0000, 32'h0001_BB68, 1'b0};   // sqrt(3) rounded
`else
    vecs[1]  = '{32'h0002_0000, 32'h0001_6A09, 1'b0};   // sqrt(2) truncated
    vecs[2]  = '{32'h0003_0000, 32'h0001_BB67, 1'b0};   // sqrt(3) truncated
`endif
    vecs[3]  = '{32'h7FFF_FFFF, 32'h00B5_04F3, 1'b0};   // largest operand
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b0};   // zero via CALC
    vecs[5]  = '{32'h0001_0000, 32'h0001_0000, 1'b0};   // 1.0
    vecs[6]  = '{32'h0009_0000, 32'h0003_0000, 1'b0};   // 9.0
    vecs[7]  = '{32'h0000_4000, 32'h0000_8000, 1'b0};   // 0.25 -> 0.5
    vecs[8]  = '{32'h0000_0001, 32'h0000_0100, 1'b0};   // 2^-16 -> 2^-8
    vecs[9]  = '{32'h0100_0000, 32'h0010_0000, 1'b0};   // 256 -> 16
    vecs[10] = '{32'hFFFF_0000, 32'h0000_0000, 1'b1};   // -1.0
    vecs[11] = '{32'h8000_0000, 32'h0000_0000, 1'b1};   // most negative

    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_radicand = '0;
    i_ready    = 1'b1;
    #12;
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_root", o_root, 32'd0);
    check("reset_invalid", {31'd0, o_invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'd0, o_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].radicand, vecs[i].exp_root, vecs[i].exp_inv, 0);
    end

    // Back-pressure: the result must stay put for 10 cycles without i_ready.
    run_op(32'h0010_0000, 32'h0004_0000, 1'b0, 10);

    // An earlier result is left on o_root, so the reset check below sees a
    // nonzero value clear.
    run_op(32'h0004_0000, 32'h0002_0000, 1'b0, 0);

    // Pulse reset during CALC step 12, away from any clock edge.
    @(negedge clk);
    i_valid    = 1'b1;
    i_radicand = 32'h0009_0000;
    @(posedge clk);                     // accept edge
    #1;
    i_valid = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_root", o_root, 32'd0);
    check("async_reset_valid", {31'd0, o_valid}, 32'd0);
    check("async_reset_invalid", {31'd0, o_invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_abort", {31'd0, o_ready}, 32'd1);
    seen_valid = 1'b0;
    for (edges = 0; edges < 40; edges++) begin
      @(posedge clk);
      #1;
      if (o_valid) seen_valid = 1'b1;
    end
    check("no_result_after_abort", {31'd0, seen_valid}, 32'd0);
    $display("op aborted by reset, radicand=0x00090000 result_seen=%0d", seen_valid);

    // The block must still work after the abort.
    run_op(32'h0009_0000, 32'h0003_0000, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
